// File: rtl/prmcu_uart_pkg.sv
// Shared constants and types for the prmcu UART receive path.
// Word width follows the UART data path (8 data bits plus optional 9th).
package prmcu_uart_pkg;

    localparam int UART_DATA_W        = 9;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_word_t;

endpackage

// File: rtl/prmcu_uart_fifo_mem.sv
// FIFO storage: register array with one synchronous write port
// and one asynchronous read port; contents are never reset.
module prmcu_uart_fifo_mem
    import prmcu_uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdat,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdat
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/prmcu_uart_rx_fifo.sv
// UART receive FIFO: never stalls the UART, drops words when full
// with a sticky overflow flag, and reports level and threshold irq.
module prmcu_uart_rx_fifo
    import prmcu_uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] in_dat_i,
    input  logic              in_vld_i,
    output logic              in_rdy_o,
    output logic [DATA_W-1:0] out_dat_o,
    output logic              out_vld_o,
    input  logic              out_rdy_i,
    input  logic [PW-1:0]     threshold_i,
    output logic [PW-1:0]     level_o,
    output logic              full_o,
    output logic              overflow_o,
    input  logic              overflow_clr_i,
    output logic              thr_irq_o
);

    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_overflow;
    logic          r_rdy;

    logic [PW-1:0] w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_level == FULL_LVL);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign w_push  = in_vld_i && r_rdy;
    assign w_pop   = !w_empty && out_rdy_i;

    // A pop in the same cycle frees the slot, so a full push still lands.
    assign w_wr_en = w_push && (!w_full || w_pop) && !clear_i;
    assign w_drop  = w_push && w_full && !w_pop && !clear_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_rdy      <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (clear_i) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end else if (overflow_clr_i) begin
                    r_overflow <= 1'b0;
                end
            end
        end
    end

    prmcu_uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdat  (in_dat_i),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdat  (out_dat_o)
    );

    assign in_rdy_o   = r_rdy;
    assign out_vld_o  = !w_empty;
    assign level_o    = w_level;
    assign full_o     = w_full;
    assign overflow_o = r_overflow;
    assign thr_irq_o  = (threshold_i != '0) && (w_level >= threshold_i);

endmodule

// File: tb/tb_prmcu_uart_rx_fifo.sv
// Directed + scoreboard bench for prmcu_uart_rx_fifo.
// A reference queue holds the expected contents and flags.
module tb_prmcu_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 9;
    localparam int PW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_i = 1'b0;
    logic [DW-1:0] in_dat_i = '0;
    logic          in_vld_i = 1'b0;
    logic          in_rdy_o;
    logic [DW-1:0] out_dat_o;
    logic          out_vld_o;
    logic          out_rdy_i = 1'b0;
    logic [PW-1:0] threshold_i = '0;
    logic [PW-1:0] level_o;
    logic          full_o;
    logic          overflow_o;
    logic          overflow_clr_i = 1'b0;
    logic          thr_irq_o;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    logic          exp_ovf = 1'b0;
    logic [DW-1:0] last_pop = '0;
    bit            acc;

    always #5 clk = ~clk;

    prmcu_uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clear_i),
        .in_dat_i       (in_dat_i),
        .in_vld_i       (in_vld_i),
        .in_rdy_o       (in_rdy_o),
        .out_dat_o      (out_dat_o),
        .out_vld_o      (out_vld_o),
        .out_rdy_i      (out_rdy_i),
        .threshold_i    (threshold_i),
        .level_o        (level_o),
        .full_o         (full_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i),
        .thr_irq_o      (thr_irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the pop about to happen, update model, check state.
    task automatic tick();
        int  n0;
        bit  pop_now;
        bit  drop;
        bit  irq;
        n0      = mq.size();
        pop_now = (n0 > 0) && out_rdy_i && !clear_i;
        chk("vld_pre", {31'b0, out_vld_o}, {31'b0, n0 > 0});
        acc  = in_vld_i && !clear_i && (n0 < DEPTH || pop_now);
        drop = in_vld_i && !clear_i && (n0 == DEPTH) && !pop_now;
        if (pop_now) begin
            chk("dat", {23'b0, out_dat_o}, {23'b0, mq[0]});
            last_pop = mq.pop_front();
        end
        if (clear_i) begin
            mq.delete();
            exp_ovf = 1'b0;
        end else begin
            if (acc) mq.push_back(in_dat_i);
            if (drop) exp_ovf = 1'b1;
            else if (overflow_clr_i) exp_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        irq = (threshold_i != 0) && (mq.size() >= int'(threshold_i));
        chk("level", {27'b0, level_o}, mq.size());
        chk("full", {31'b0, full_o}, {31'b0, mq.size() == DEPTH});
        chk("ovf", {31'b0, overflow_o}, {31'b0, exp_ovf});
        chk("irq", {31'b0, thr_irq_o}, {31'b0, irq});
    endtask

    initial begin
        int pushed;
        int guard;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", {31'b0, in_rdy_o}, 0);
        chk("rst_vld", {31'b0, out_vld_o}, 0);
        chk("rst_level", {27'b0, level_o}, 0);
        chk("rst_full", {31'b0, full_o}, 0);
        chk("rst_ovf", {31'b0, overflow_o}, 0);
        chk("rst_irq", {31'b0, thr_irq_o}, 0);
        rst = 1'b0;
        chk("rdy_hold", {31'b0, in_rdy_o}, 0);
        @(posedge clk);
        #1;
        chk("rdy_up", {31'b0, in_rdy_o}, 1);
        tick();
        tick();
        chk("idle_vld", {31'b0, out_vld_o}, 0);

        // single word
        in_vld_i = 1'b1;
        in_dat_i = 9'h0A5;
        tick();
        in_vld_i = 1'b0;
        chk("one_vld", {31'b0, out_vld_o}, 1);
        chk("one_dat", {23'b0, out_dat_o}, 32'h0A5);
        chk("one_lvl", {27'b0, level_o}, 1);
        out_rdy_i = 1'b1;
        tick();
        out_rdy_i = 1'b0;
        chk("one_pop", {27'b0, level_o}, 0);

        // fill and overflow; 17th push coincides with a clear (set wins)
        for (int i = 0; i <= 16; i++) begin
            in_vld_i = 1'b1;
            in_dat_i = DW'(i);
            overflow_clr_i = (i == 16);
            tick();
            if (i == 15) begin
                chk("fill_full", {31'b0, full_o}, 1);
                chk("fill_noovf", {31'b0, overflow_o}, 0);
            end
        end
        in_vld_i = 1'b0;
        overflow_clr_i = 1'b0;
        chk("ovf_set", {31'b0, overflow_o}, 1);
        chk("ovf_lvl", {27'b0, level_o}, 16);
        overflow_clr_i = 1'b1;
        tick();
        overflow_clr_i = 1'b0;
        chk("ovf_clr", {31'b0, overflow_o}, 0);
        out_rdy_i = 1'b1;
        repeat (16) tick();
        out_rdy_i = 1'b0;
        chk("drain_last", {23'b0, last_pop}, 32'h00F);
        chk("drain_empty", {31'b0, out_vld_o}, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            in_vld_i = 1'b1;
            in_dat_i = DW'($urandom_range(0, 255));
            tick();
        end
        in_dat_i  = 9'h1FF;
        out_rdy_i = 1'b1;
        tick();
        in_vld_i = 1'b0;
        chk("pp_lvl", {27'b0, level_o}, 16);
        chk("pp_ovf", {31'b0, overflow_o}, 0);
        repeat (16) tick();
        out_rdy_i = 1'b0;
        chk("pp_last", {23'b0, last_pop}, 32'h1FF);

        // threshold
        threshold_i = 5'd4;
        for (int i = 0; i < 4; i++) begin
            in_vld_i = 1'b1;
            in_dat_i = DW'(9'h100 + i);
            tick();
            if (i == 2) chk("thr_3", {31'b0, thr_irq_o}, 0);
        end
        in_vld_i = 1'b0;
        chk("thr_4", {31'b0, thr_irq_o}, 1);
        out_rdy_i = 1'b1;
        tick();
        out_rdy_i = 1'b0;
        chk("thr_pop", {31'b0, thr_irq_o}, 0);
        threshold_i = 5'd0;
        in_vld_i = 1'b1;
        repeat (14) tick();
        in_vld_i = 1'b0;
        chk("thr_off", {31'b0, thr_irq_o}, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;

        // random traffic, pointers wrap
        pushed = 0;
        guard  = 0;
        while (pushed < 40 && guard < 400) begin
            in_vld_i  = 1'b1;
            in_dat_i  = DW'($urandom_range(0, 511));
            out_rdy_i = $urandom_range(0, 1) == 1;
            tick();
            if (acc) pushed++;
            guard++;
        end
        chk("rand_budget", {31'b0, pushed >= 40}, 1);
        in_vld_i  = 1'b0;
        out_rdy_i = 1'b1;
        guard = 0;
        while (mq.size() > 0 && guard < 40) begin
            tick();
            guard++;
        end
        out_rdy_i = 1'b0;
        chk("rand_drain", {31'b0, out_vld_o}, 0);

        // clear with concurrent push
        for (int i = 0; i < 5; i++) begin
            in_vld_i = 1'b1;
            in_dat_i = DW'(9'h0C0 + i);
            tick();
        end
        in_dat_i = 9'h155;
        clear_i  = 1'b1;
        tick();
        clear_i  = 1'b0;
        in_vld_i = 1'b0;
        chk("clr_lvl", {27'b0, level_o}, 0);
        chk("clr_ovf", {31'b0, overflow_o}, 0);
        tick();
        chk("clr_lost", {31'b0, out_vld_o}, 0);

        // clear also drops a pending overflow
        in_vld_i = 1'b1;
        repeat (17) tick();
        in_vld_i = 1'b0;
        chk("ovf2_set", {31'b0, overflow_o}, 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("ovf2_clr", {31'b0, overflow_o}, 0);
        chk("ovf2_lvl", {27'b0, level_o}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
